// File: rtl/udp_axil_master.sv
// UDP command packet to AXI-Lite initiator: one read/write per packet, one reply packet per command.
// Optional build macro AXIL_TIMEOUT_EN bounds the B/R wait to TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | waiting for command header W0
// ADDR  | waiting for address word W1
// WDATA | waiting for write data word W2
// DRAIN | discarding words up to tlast (extra words or malformed packet)
// WR    | AW and W channels presented, each retired on its own ready
// WRESP | waiting for B response
// RD    | AR channel presented
// RRESP | waiting for R response
// TX0   | sending reply header
// TX1   | sending reply address (last word for writes)
// TX2   | sending read data (last word for reads)
module udp_axil_master #(
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [15:0] RESP_PORT   = 16'd0
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        rx_tvalid_i,
    input  logic [31:0] rx_tdata_i,
    input  logic [31:0] rx_tuser_i,
    input  logic [3:0]  rx_tkeep_i,
    input  logic        rx_tlast_i,
    output logic        rx_tready_o,
    output logic        tx_tvalid_o,
    output logic [31:0] tx_tdata_o,
    output logic [63:0] tx_tuser_o,
    output logic [3:0]  tx_tkeep_o,
    output logic        tx_tlast_o,
    input  logic        tx_tready_i,
    output logic [31:0] m_awaddr_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    output logic [31:0] m_araddr_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [3:0] OP_WR = 4'h1;
    localparam logic [3:0] OP_RD = 4'h2;

    typedef enum logic [3:0] {
        IDLE, ADDR, WDATA, DRAIN, WR, WRESP, RD, RRESP, TX0, TX1, TX2
    } state_t;

    state_t      state, state_nxt;
    logic        rx_fire, tx_fire, hdr_bad, err_inc, tmo_hit;
    logic        drain_err_q, aw_done_q, w_done_q;
    logic [3:0]  op_q;
    logic [7:0]  tag_q;
    logic [31:0] user_q, addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;
    logic [15:0] err_cnt_q;
    logic        unused_ok;

    // Header reserved bits are not checked; only the opcode decides validity.
    assign unused_ok = ^{rx_tdata_i[27:8], (TIMEOUT_CYC != 0)};

    assign hdr_bad = (rx_tdata_i[31:28] != OP_WR) && (rx_tdata_i[31:28] != OP_RD);

    // Ready gated by reset so nothing is accepted while reset is held.
    assign rx_tready_o = reset && ((state == IDLE) || (state == ADDR) ||
                                   (state == WDATA) || (state == DRAIN));
    assign rx_fire     = rx_tvalid_i && rx_tready_o;
    assign tx_fire     = tx_tvalid_o && tx_tready_i;

    assign m_awvalid_o = (state == WR) && !aw_done_q;
    assign m_wvalid_o  = (state == WR) && !w_done_q;
    assign m_arvalid_o = (state == RD);
    assign m_awaddr_o  = {addr_q[31:2], 2'b00};
    assign m_araddr_o  = {addr_q[31:2], 2'b00};
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign err_cnt_o   = err_cnt_q;

`ifdef AXIL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt_q;

    // Down-counter reloads outside the wait states; zero while still waiting means expiry.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if ((state == WRESP) || (state == RRESP)) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end else begin
            tmo_cnt_q <= TMO_W'(TIMEOUT_CYC - 1);
        end
    end

    assign tmo_hit = (tmo_cnt_q == '0);
    // Late responses after a timeout are soaked up while idle.
    assign m_bready_o = (state == WRESP) || (reset && (state == IDLE));
    assign m_rready_o = (state == RRESP) || (reset && (state == IDLE));
`else
    assign tmo_hit    = 1'b0;
    assign m_bready_o = (state == WRESP);
    assign m_rready_o = (state == RRESP);
`endif

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_tlast_i || hdr_bad) begin
                        err_inc   = 1'b1;
                        state_nxt = rx_tlast_i ? IDLE : DRAIN;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    if (op_q == OP_WR) begin
                        if (rx_tlast_i) begin
                            err_inc   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = WDATA;
                        end
                    end else begin
                        state_nxt = rx_tlast_i ? RD : DRAIN;
                    end
                end
            end
            WDATA: begin
                if (rx_fire) begin
                    state_nxt = rx_tlast_i ? WR : DRAIN;
                end
            end
            DRAIN: begin
                if (rx_fire && rx_tlast_i) begin
                    if (drain_err_q) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (op_q == OP_RD) ? RD : WR;
                    end
                end
            end
            WR: begin
                if ((aw_done_q || m_awready_i) && (w_done_q || m_wready_i)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid_i || tmo_hit) begin
                    state_nxt = TX0;
                end
            end
            RD: begin
                if (m_arready_i) begin
                    state_nxt = RRESP;
                end
            end
            RRESP: begin
                if (m_rvalid_i || tmo_hit) begin
                    state_nxt = TX0;
                end
            end
            TX0: begin
                if (tx_fire) begin
                    state_nxt = TX1;
                end
            end
            TX1: begin
                if (tx_fire) begin
                    state_nxt = (op_q == OP_RD) ? TX2 : IDLE;
                end
            end
            TX2: begin
                if (tx_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            tag_q       <= '0;
            user_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            err_cnt_q   <= '0;
            drain_err_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            if (err_inc && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (state != WR) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        op_q        <= rx_tdata_i[31:28];
                        tag_q       <= rx_tdata_i[7:0];
                        user_q      <= rx_tuser_i;
                        drain_err_q <= err_inc;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr_q <= rx_tdata_i;
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        wdata_q <= rx_tdata_i;
                        wstrb_q <= rx_tkeep_i;
                    end
                end
                WR: begin
                    if (m_awvalid_o && m_awready_i) begin
                        aw_done_q <= 1'b1;
                    end
                    if (m_wvalid_o && m_wready_i) begin
                        w_done_q <= 1'b1;
                    end
                end
                WRESP: begin
                    if (m_bvalid_i) begin
                        resp_q <= m_bresp_i;
                    end else if (tmo_hit) begin
                        resp_q  <= 2'b11;
                        rdata_q <= 32'hDEAD_BEEF;
                    end
                end
                RRESP: begin
                    if (m_rvalid_i) begin
                        resp_q  <= m_rresp_i;
                        rdata_q <= m_rdata_i;
                    end else if (tmo_hit) begin
                        resp_q  <= 2'b11;
                        rdata_q <= 32'hDEAD_BEEF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        tx_tvalid_o = 1'b0;
        tx_tdata_o  = '0;
        tx_tlast_o  = 1'b0;
        case (state)
            TX0: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = {op_q | 4'h8, 2'b00, resp_q, 16'h0000, tag_q};
            end
            TX1: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = addr_q;
                tx_tlast_o  = (op_q != OP_RD);
            end
            TX2: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = rdata_q;
                tx_tlast_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign tx_tkeep_o = tx_tvalid_o ? 4'hF : 4'h0;
    assign tx_tuser_o = {user_q, 16'h0000, RESP_PORT};

endmodule

// File: doc/udp_axil_master.md
Name: udp_axil_master

Overview:
- Command-packet-to-AXI-Lite initiator: consumes UDP user-RX stream words, decodes single read/write commands, drives the AXI-Lite master side that feeds BRAM-style slaves, returns one response packet per command on the UDP user-TX stream.
- Sits between udp_top user ports and any AXI-Lite slave on sclk; remote host peeks/pokes registers over Ethernet.

Parameters:
- TIMEOUT_CYC, 1024, sclk cycles waited for BVALID/RVALID before forced error response (used only with AXIL_TIMEOUT_EN).
- RESP_PORT, 16'd0, value placed in tx_user_o[15:0] (reply destination port field).

Ports:
- sclk  in  1  clock
- reset  in  1  async active-low reset
- rx_tvalid_i  in  1  RX stream valid
- rx_tdata_i  in  32  RX word
- rx_tuser_i  in  32  RX side info (source IP), sampled on header word
- rx_tkeep_i  in  4  RX byte enables
- rx_tlast_i  in  1  last word of packet
- rx_tready_o  out  1  RX ready
- tx_tvalid_o  out  1  TX valid
- tx_tdata_o  out  32  TX word
- tx_tuser_o  out  64  {latched rx_tuser, 16'h0, RESP_PORT}
- tx_tkeep_o  out  4  always 4'hF while valid
- tx_tlast_o  out  1  last response word
- tx_tready_i  in  1  TX ready
- m_awaddr_o out 32, m_awvalid_o out 1, m_awready_i in 1
- m_wdata_o out 32, m_wstrb_o out 4, m_wvalid_o out 1, m_wready_i in 1
- m_bresp_i in 2, m_bvalid_i in 1, m_bready_o out 1
- m_araddr_o out 32, m_arvalid_o out 1, m_arready_i in 1
- m_rdata_i in 32, m_rresp_i in 2, m_rvalid_i in 1, m_rready_o out 1
- err_cnt_o  out  16  malformed-packet counter, saturating at 16'hFFFF

Behaviour:
- Reset (reset=0, async): all valid/ready outputs 0, data/addr outputs 0, err_cnt_o 0, FSM IDLE.
- Command format: W0 = {opcode[31:28], 20'h0, tag[7:0]}, opcode 4'h1 write, 4'h2 read; W1 = address; W2 = write data (write only), m_wstrb_o = rx_tkeep_i of W2.
- Address low two bits forced to 0 on m_awaddr_o/m_araddr_o.
- States: IDLE, ADDR, WDATA, DRAIN, WR, WRESP, RD, RRESP, TX0, TX1, TX2.
- rx_tready_o = 1 only in IDLE/ADDR/WDATA/DRAIN; word accepted when rx_tvalid_i & rx_tready_o.
- IDLE: accept W0, latch opcode/tag/rx_tuser -> ADDR; tlast on W0 or bad opcode -> error path.
- ADDR: accept W1 -> write: WDATA; read: RD. tlast here for write -> error path.
- WDATA: accept W2 -> if !tlast then DRAIN (extra words discarded, command still executed) else WR.
- Read: extra words after W1 drained in DRAIN before RD.
- Error path: increment err_cnt_o, DRAIN to tlast (or return to IDLE if already tlast); no AXI, no response.
- WR: assert awvalid and wvalid in the same cycle; each deasserts independently on its own ready; -> WRESP when both done. Handles aw/w ready in either order or together.
- WRESP: m_bready_o=1; on bvalid latch bresp -> TX0.
- RD: arvalid until arready -> RRESP; m_rready_o=1, latch rdata/rresp on rvalid -> TX0.
- Valid signals held stable until handshake; no combinational path from ready inputs to valid outputs.
- Response: W0 = {opcode|4'h8, 2'b0, resp[1:0], 16'h0, tag}; W1 = address; W2 = rdata (read only). tlast on W1 for write, W2 for read. Each word held until tx_tready_i.
- Last TX handshake -> IDLE; next command header accepted the following cycle.
- One outstanding command; RX backpressured during AXI/TX phases.
- Latency: W2/W1 acceptance to awvalid/arvalid = 1 cycle; B/R handshake to tx_tvalid_o = 1 cycle.

Optional Feature:
- Macro AXIL_TIMEOUT_EN.
- Defined: counter starts on entering WRESP/RRESP; reaching TIMEOUT_CYC without bvalid/rvalid -> resp = 2'b11, rdata = 32'hDEAD_BEEF, go TX0; bready/rready dropped. Any late B/R is still accepted and discarded in IDLE.
- Undefined: wait indefinitely; 2'b11 never produced.

Test Plan:
- Write: W0=32'h1000_0005, W1=32'h0000_0013, W2=32'hCAFE_F00D tkeep F, tlast -> awaddr 32'h10, wdata CAFEF00D, wstrb F; bresp 0 -> TX 32'h9000_0005, 32'h0000_0013 (tlast).
- Read: W0=32'h2000_00A1, W1=32'h20 -> araddr 32'h20; rdata 32'h1234_5678, rresp 0 -> TX 32'hA000_00A1, 32'h20, 32'h1234_5678 (tlast).
- aw/w ordering: wready 3 cycles before awready, then the reverse -> exactly one AW and one W handshake each; response sent once.
- Malformed: W0=32'h3000_0001 + 2 words, tlast -> no AXI activity, err_cnt_o 0 -> 1, next valid read still served.
- TX backpressure: tx_tready_i low 5 cycles per word -> words stable, order intact, rx_tready_o stays 0.
- AXIL_TIMEOUT_EN, TIMEOUT_CYC=16, rvalid never asserted -> at 16 cycles TX 32'hA300_00tag, addr, 32'hDEADBEEF; reset asserted mid-RRESP -> all outputs 0 immediately.
